// File: rtl/dm_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store ports.
// Each access runs IDLE -> ACCESS (LAT cycles) -> RESP (one-cycle ready pulse).
module dm_mem_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;   // 1 = data port, 0 = fetch
  logic               last_q, last_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic               d_req;
  logic               grant_d;

  assign d_req = memread | memwrite;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    // On a tie the data port wins unless it was the last one served.
    grant_d     = d_req & (~if_req | ~last_q);
    unique case (state_q)
      IDLE: begin
        if (if_req | d_req) begin
          owner_d     = grant_d;
          mem_addr_d  = grant_d ? d_addr : if_addr;
          mem_wdata_d = d_wdata;
          mem_we_d    = grant_d & memwrite;
          cnt_d       = CNT_W'(LAT - 1);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!mem_we_q) begin
            if (owner_q) d_rdata_d  = mem_rdata;
            else         if_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = (state_q == ACCESS);
    mem_we    = (state_q == ACCESS) & mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    if_ready  = (state_q == RESP) & ~owner_q;
    d_ready   = (state_q == RESP) & owner_q;
    if_stall  = if_req & ~((state_q == RESP) & ~owner_q);
    d_stall   = d_req & ~((state_q == RESP) & owner_q);
  end

endmodule

// File: tb/tb_dm_mem_arbiter.sv
// Directed bench for dm_mem_arbiter: one LAT=2 instance and one LAT=1 instance.
module tb_dm_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // LAT=2 instance
  logic        if_req, memread, memwrite;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, if_stall, d_ready, d_stall, mem_en, mem_we;

  // LAT=1 instance
  logic        if_req1, memread1, memwrite1;
  logic [31:0] if_addr1, d_addr1, d_wdata1, mem_rdata1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        if_ready1, if_stall1, d_ready1, d_stall1, mem_en1, mem_we1;

  int n_vec = 0;
  int n_bad = 0;

  // Memory model: 0x10 holds a marker, every other word is its address xor a tag.
  assign mem_rdata  = (mem_addr  == 32'h10) ? 32'hDEADBEEF : (mem_addr  ^ 32'hA5A5_0000);
  assign mem_rdata1 = (mem_addr1 == 32'h10) ? 32'hDEADBEEF : (mem_addr1 ^ 32'hA5A5_0000);

  dm_mem_arbiter #(.LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_stall(if_stall),
    .memread(memread), .memwrite(memwrite), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dm_mem_arbiter #(.LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1),
    .if_ready(if_ready1), .if_stall(if_stall1),
    .memread(memread1), .memwrite(memwrite1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_ready(d_ready1), .d_stall(d_stall1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {mem_en, mem_we, if_ready, d_ready, if_stall, d_stall}
  function automatic logic [31:0] sig0();
    return {26'd0, mem_en, mem_we, if_ready, d_ready, if_stall, d_stall};
  endfunction
  function automatic logic [31:0] sig1();
    return {26'd0, mem_en1, mem_we1, if_ready1, d_ready1, if_stall1, d_stall1};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] e5 [0:4];
  logic [5:0] e9 [0:8];
  logic [5:0] e3 [0:2];

  initial begin
    reset = 1'b1;
    {if_req, memread, memwrite} = '0;
    {if_req1, memread1, memwrite1} = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    if_addr1 = '0; d_addr1 = '0; d_wdata1 = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_sig", sig0(), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_drdata", d_rdata, 32'h0);
    chk("rst_sig1", sig1(), 32'h0);
    next_cycle();

    // Single load, address changed after grant must be ignored
    e5 = '{6'b000001, 6'b100001, 6'b100001, 6'b000100, 6'b000000};
    memread = 1'b1; d_addr = 32'h10;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) d_addr = 32'h44;
      if (c == 4) memread = 1'b0;
      @(negedge clk);
      chk($sformatf("load_c%0d", c), sig0(), {26'd0, e5[c]});
      if (c == 2) chk("load_addr", mem_addr, 32'h10);
      if (c == 3) chk("load_rdata", d_rdata, 32'hDEADBEEF);
      next_cycle();
    end

    // Store
    e5 = '{6'b000001, 6'b110001, 6'b110001, 6'b000100, 6'b000000};
    memwrite = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) memwrite = 1'b0;
      @(negedge clk);
      chk($sformatf("store_c%0d", c), sig0(), {26'd0, e5[c]});
      if (c == 1) chk("store_addr", mem_addr, 32'h20);
      if (c == 2) chk("store_wdata", mem_wdata, 32'h12345678);
      if (c == 3) chk("store_rdata", d_rdata, 32'hDEADBEEF);
      next_cycle();
    end

    // Simultaneous requests straight out of reset
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    e9 = '{6'b000011, 6'b100011, 6'b100011, 6'b000110, 6'b000010,
           6'b100010, 6'b100010, 6'b001000, 6'b000000};
    if_req = 1'b1; if_addr = 32'h100; memread = 1'b1; d_addr = 32'h10;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) memread = 1'b0;
      if (c == 8) if_req = 1'b0;
      @(negedge clk);
      chk($sformatf("both_c%0d", c), sig0(), {26'd0, e9[c]});
      if (c == 3) chk("both_drdata", d_rdata, 32'hDEADBEEF);
      if (c == 5) chk("both_faddr", mem_addr, 32'h100);
      if (c == 7) chk("both_irdata", if_rdata, 32'hA5A50100);
      next_cycle();
    end

    // Fairness: both held continuously, grants alternate D, IF, D, IF
    if_req = 1'b1; memread = 1'b1;
    for (int c = 0; c < 16; c++) begin
      logic [1:0] exp_rdy;
      exp_rdy = (c % 4 != 3) ? 2'b00 : (((c / 4) % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      chk($sformatf("fair_c%0d", c), {30'd0, if_ready, d_ready}, {30'd0, exp_rdy});
      next_cycle();
    end
    if_req = 1'b0; memread = 1'b0;
    next_cycle();

    // Reset during ACCESS, request held through reset restarts
    memread = 1'b1; d_addr = 32'h40;
    e9 = '{6'b000001, 6'b100001, 6'b100001, 6'b000001, 6'b100001,
           6'b100001, 6'b000100, 6'b000000, 6'b000000};
    for (int c = 0; c < 8; c++) begin
      if (c == 2) reset = 1'b1;
      if (c == 3) reset = 1'b0;
      if (c == 7) memread = 1'b0;
      @(negedge clk);
      chk($sformatf("rstmid_c%0d", c), sig0(), {26'd0, e9[c]});
      if (c == 3) begin
        chk("rstmid_addr", mem_addr, 32'h0);
        chk("rstmid_irdata", if_rdata, 32'h0);
      end
      if (c == 6) chk("rstmid_rdata", d_rdata, 32'hA5A50040);
      next_cycle();
    end

    // LAT=1: plain load, then read+write conflict treated as a store
    e3 = '{6'b000001, 6'b100001, 6'b000100};
    memread1 = 1'b1; d_addr1 = 32'h10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("l1load_c%0d", c), sig1(), {26'd0, e3[c]});
      if (c == 2) chk("l1load_rdata", d_rdata1, 32'hDEADBEEF);
      next_cycle();
    end
    memread1 = 1'b0;
    next_cycle();
    e3 = '{6'b000001, 6'b110001, 6'b000100};
    memread1 = 1'b1; memwrite1 = 1'b1; d_addr1 = 32'h50; d_wdata1 = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("l1rw_c%0d", c), sig1(), {26'd0, e3[c]});
      if (c == 1) chk("l1rw_wdata", mem_wdata1, 32'hCAFEF00D);
      if (c == 2) chk("l1rw_rdata", d_rdata1, 32'hDEADBEEF);
      next_cycle();
    end
    memread1 = 1'b0; memwrite1 = 1'b0;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_mem_arbiter.md
# dm_mem_arbiter

Arbitrates a single-port, fixed-latency unified memory between the instruction-fetch port and the data-memory (load/store) port of the MIPS pipeline. It sequences each access through a small state machine and returns read data with a one-cycle ready pulse. It also generates per-port stall signals that hold the pipeline until the granted access completes. It sits between the IF/MEM stages and the memory macro, and replaces the PC-compare busy heuristic with an explicit request/ready handshake.

## Interface
- `LAT`, 2: memory access cycles per transaction (≥1); `mem_rdata` is valid in the last ACCESS cycle.
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request; held until `if_ready`.
- `if_addr` in 32: fetch address, word aligned.
- `if_rdata` out 32: registered fetch data.
- `if_ready` out 1: one-cycle completion pulse for fetch.
- `if_stall` out 1: `if_req & ~if_ready`.
- `memread` in 1: load request; held until `d_ready`.
- `memwrite` in 1: store request; held until `d_ready`.
- `d_addr` in 32: load/store address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: registered load data.
- `d_ready` out 1: one-cycle completion pulse for data port.
- `d_stall` out 1: `(memread | memwrite) & ~d_ready`.
- `mem_en` out 1: memory enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: registered address to memory.
- `mem_wdata` out 32: registered write data.
- `mem_rdata` in 32: memory read data.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: sample requests. The data request is `memread | memwrite`.
  - If exactly one port requests, grant it.
  - If both request, grant the port not granted last. Register `last` holds the last-granted port and resets to IF, so the first tie goes to data.
  - On a grant: latch owner, `mem_addr`, `mem_wdata`, and `mem_we` (`memwrite` for data, 0 for IF), load counter with LAT-1, go to ACCESS.
- ACCESS: `mem_en`=1 and `mem_we`/`mem_addr`/`mem_wdata` stable.
  - Counter decrements each cycle.
  - When counter==0:
    - read: capture `mem_rdata` into the owner's rdata register;
    - write: `d_rdata` is unchanged;
    - go to RESP.
- RESP: assert the owner's ready for exactly one cycle, drop `mem_en`/`mem_we`, update `last`, go to IDLE.
- `memread` and `memwrite` both high: treated as a store (`mem_we`=1); `d_rdata` is not updated.
- Requests arriving in ACCESS/RESP are not sampled; they wait for IDLE.
- Address/data changes while a request is held are ignored after the grant (values are latched).
- A requester dropping its request mid-transaction does not abort it; the access completes and the ready pulse is still issued.
- `if_ready` and `d_ready` are never high in the same cycle.

## Timing
- Request high in IDLE in cycle 0 → ACCESS cycles 1..LAT → ready in cycle LAT+1 → IDLE in cycle LAT+2.
- The requester updates or drops its request at the edge ending the ready cycle. Back-to-back throughput is one access per LAT+2 cycles.
- Stalls are combinational from the request and ready signals; `rdata` is valid from the ready cycle onward until the owner's next read completes.
- Reset (any state, including mid-ACCESS):
  - next cycle: state=IDLE, `mem_en`=`mem_we`=0, `mem_addr`=`mem_wdata`=0, `if_rdata`=`d_rdata`=0, `if_ready`=`d_ready`=0, counter=0, `last`=IF;
  - an aborted transaction produces no ready pulse.
- A request held through reset is granted in the first IDLE cycle after reset deasserts.
- LAT=1: a single ACCESS cycle, ready in cycle 2.

## Test plan
- **Single load, LAT=2:** `memread`=1, `d_addr`=0x10, memory returns 0xDEADBEEF → `mem_en` high in cycles 1–2, `d_ready` pulse in cycle 3 with `d_rdata`=0xDEADBEEF, `d_stall` high cycles 0–2.
- **Store:** `memwrite`=1, `d_addr`=0x20, `d_wdata`=0x12345678 → `mem_we`=1 with that addr/data for 2 cycles, `d_ready` in cycle 3, `d_rdata` unchanged, `if_ready` never asserted.
- **Simultaneous requests from reset:** `if_req` and `memread` held high from cycle 0.
  - Data is served first, with `d_ready` in cycle 3.
  - Fetch is granted in cycle 4, with `if_ready` in cycle 7.
  - `if_stall` stays high through cycle 6.
- **Fairness:** both ports request continuously (each re-requests the cycle after its ready) → grants alternate D, IF, D, IF; no port waits more than 2×(LAT+2) cycles.
- **Reset mid-access:** assert `reset` in cycle 2 of a load → `mem_en`=0 and all outputs 0 next cycle, no `d_ready`. With `memread` still high after reset, the load restarts and completes LAT+1 cycles after the first IDLE.
- **LAT=1 and read+write conflict:** `memread`=`memwrite`=1 → a single write cycle with `mem_we`=1, `d_ready` in cycle 2, `d_rdata` unchanged.
